// File: rtl/q_proj_pkg.sv
// Shared types for the Q-projection systolic array: feeder FSM states and the PE element type.
package q_proj_pkg;

    localparam int DATA_WIDTH = 8;

    typedef logic signed [DATA_WIDTH-1:0] lane_t;

    typedef enum logic [1:0] {
        StIdle,
        StFeed,
        StFlush,
        StDone
    } feeder_state_t;

endpackage

// File: rtl/skew_delay_line.sv
// Fixed-depth shift register used to skew one lane of an array edge; clears to zero on reset.
module skew_delay_line #(
    parameter int DEPTH = 1,
    parameter int WIDTH = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [WIDTH-1:0] din,
    output logic [WIDTH-1:0] dout
);

    logic [WIDTH-1:0] stage_q [DEPTH];

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int i = 0; i < DEPTH; i++) begin
                stage_q[i] <= '0;
            end
        end else begin
            stage_q[0] <= din;
            for (int i = 1; i < DEPTH; i++) begin
                stage_q[i] <= stage_q[i-1];
            end
        end
    end

    assign dout = stage_q[DEPTH-1];

endmodule

// File: rtl/pe_skew_feeder.sv
// Skewed edge feeder for the Q-projection PE array; zero-fills bubbles and the drain tail.
// Optional stall counter output enabled by defining PE_FEEDER_STALL_CNT_EN.
module pe_skew_feeder
    import q_proj_pkg::*;
#(
    parameter int N          = 4,
    parameter int DATA_WIDTH = q_proj_pkg::DATA_WIDTH,
    parameter int K_MAX      = 64,
    localparam int KW        = $clog2(K_MAX + 1)
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic                    start,
    input  logic [KW-1:0]           k_len,
    input  logic                    a_valid,
    output logic                    a_ready,
    input  logic [N*DATA_WIDTH-1:0] a_vec,
    input  logic                    b_valid,
    output logic                    b_ready,
    input  logic [N*DATA_WIDTH-1:0] b_vec,
    output logic [N*DATA_WIDTH-1:0] edge_a,
    output logic [N*DATA_WIDTH-1:0] edge_b,
    output logic                    busy,
    output logic                    done
`ifdef PE_FEEDER_STALL_CNT_EN
    ,
    output logic [31:0]             stall_cnt
`endif
);

    // Drain time until the far-corner PE has absorbed the last step
    localparam int FLUSH_LEN = 2 * N - 1;
    localparam int FW        = $clog2(FLUSH_LEN + 1);

    feeder_state_t state_q, state_d;
    logic [KW-1:0] k_len_q, k_len_d;
    logic [KW-1:0] step_cnt_q, step_cnt_d;
    logic [FW-1:0] flush_cnt_q, flush_cnt_d;
    logic          accept;
    logic          start_ok;

    logic [N*DATA_WIDTH-1:0] entry_a, entry_b;

    assign start_ok = start && (k_len != '0);

    always_comb begin
        state_d     = state_q;
        k_len_d     = k_len_q;
        step_cnt_d  = step_cnt_q;
        flush_cnt_d = flush_cnt_q;
        accept      = 1'b0;
        a_ready     = 1'b0;
        b_ready     = 1'b0;
        busy        = 1'b0;
        done        = 1'b0;
        unique case (state_q)
            StIdle: begin
                if (start_ok) begin
                    state_d    = StFeed;
                    k_len_d    = k_len;
                    step_cnt_d = '0;
                end
            end
            StFeed: begin
                busy    = 1'b1;
                // Each side's ready follows the other's valid so both streams move together
                a_ready = b_valid;
                b_ready = a_valid;
                accept  = a_valid && b_valid;
                if (accept) begin
                    if (step_cnt_q == k_len_q - 1'b1) begin
                        state_d     = StFlush;
                        step_cnt_d  = '0;
                        flush_cnt_d = '0;
                    end else begin
                        step_cnt_d = step_cnt_q + 1'b1;
                    end
                end
            end
            StFlush: begin
                busy = 1'b1;
                if (flush_cnt_q == FW'(FLUSH_LEN - 1)) begin
                    state_d     = StDone;
                    flush_cnt_d = '0;
                end else begin
                    flush_cnt_d = flush_cnt_q + 1'b1;
                end
            end
            StDone: begin
                done    = 1'b1;
                state_d = StIdle;
            end
            default: state_d = StIdle;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q     <= StIdle;
            k_len_q     <= '0;
            step_cnt_q  <= '0;
            flush_cnt_q <= '0;
        end else begin
            state_q     <= state_d;
            k_len_q     <= k_len_d;
            step_cnt_q  <= step_cnt_d;
            flush_cnt_q <= flush_cnt_d;
        end
    end

    assign entry_a = accept ? a_vec : '0;
    assign entry_b = accept ? b_vec : '0;

    for (genvar i = 0; i < N; i++) begin : g_lane
        skew_delay_line #(
            .DEPTH(i + 1),
            .WIDTH(DATA_WIDTH)
        ) u_skew_a (
            .clk (clk),
            .rst (rst),
            .din (entry_a[i*DATA_WIDTH +: DATA_WIDTH]),
            .dout(edge_a[i*DATA_WIDTH +: DATA_WIDTH])
        );
        skew_delay_line #(
            .DEPTH(i + 1),
            .WIDTH(DATA_WIDTH)
        ) u_skew_b (
            .clk (clk),
            .rst (rst),
            .din (entry_b[i*DATA_WIDTH +: DATA_WIDTH]),
            .dout(edge_b[i*DATA_WIDTH +: DATA_WIDTH])
        );
    end

`ifdef PE_FEEDER_STALL_CNT_EN
    logic [31:0] stall_cnt_q;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            stall_cnt_q <= '0;
        end else if (state_q == StIdle && start_ok) begin
            stall_cnt_q <= '0;
        end else if (state_q == StFeed && !accept && stall_cnt_q != '1) begin
            stall_cnt_q <= stall_cnt_q + 1'b1;
        end
    end

    assign stall_cnt = stall_cnt_q;
`endif

endmodule

// File: tb/tb_pe_skew_feeder.sv
// Directed bench for pe_skew_feeder: edge skew, bubble fill and PE sums via an array model.
module tb_pe_skew_feeder;

    localparam int N  = 4;
    localparam int DW = 8;
    localparam int W  = N * DW;
    localparam int KW = 7;

    logic          clk = 1'b0;
    logic          rst;
    logic          start;
    logic [KW-1:0] k_len;
    logic          a_valid, a_ready, b_valid, b_ready;
    logic [W-1:0]  a_vec, b_vec, edge_a, edge_b;
    logic          busy, done;
`ifdef PE_FEEDER_STALL_CNT_EN
    logic [31:0]   stall_cnt;
`endif

    pe_skew_feeder #(
        .N         (N),
        .DATA_WIDTH(DW),
        .K_MAX     (64)
    ) dut (
        .clk    (clk),
        .rst    (rst),
        .start  (start),
        .k_len  (k_len),
        .a_valid(a_valid),
        .a_ready(a_ready),
        .a_vec  (a_vec),
        .b_valid(b_valid),
        .b_ready(b_ready),
        .b_vec  (b_vec),
        .edge_a (edge_a),
        .edge_b (edge_b),
        .busy   (busy),
        .done   (done)
`ifdef PE_FEEDER_STALL_CNT_EN
        ,
        .stall_cnt(stall_cnt)
`endif
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    int n_checks = 0;
    int n_pass   = 0;

    // Scoreboard: expected done cycle and N*N PE sums per completed job
    int done_q[$];
    int sum_q[$];

    int   exp_sum [N][N];
    int   last_l;
    logic exp_acc;

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_checks++;
        assert (obs === exp) n_pass++;
        else $error("FAIL %s: observed %0h, expected %0h", tag, obs, exp);
    endtask

    function automatic int lane(input logic [W-1:0] v, input int i);
        logic signed [DW-1:0] t;
        t = v[i*DW +: DW];
        return int'(t);
    endfunction

    function automatic logic [W-1:0] ramp(input int base, input int stride);
        logic [W-1:0] r;
        int x;
        for (int i = 0; i < N; i++) begin
            x = base + stride * i;
            r[i*DW +: DW] = x[DW-1:0];
        end
        return r;
    endfunction

    // Array model fed from the DUT edges; compared against bench-computed sums at done
    int                   acc [N][N];
    logic signed [DW-1:0] pa  [N][N];
    logic signed [DW-1:0] pb  [N][N];
    logic [W-1:0]         hist_a [N];
    logic [W-1:0]         hist_b [N];
    logic [W-1:0]         exp_ea, exp_eb;
    logic signed [DW-1:0] in_a, in_b;

    always @(negedge clk) begin
        if (rst) begin
            for (int i = 0; i < N; i++) begin
                hist_a[i] = '0;
                hist_b[i] = '0;
                for (int j = 0; j < N; j++) begin
                    acc[i][j] = 0;
                    pa[i][j]  = '0;
                    pb[i][j]  = '0;
                end
            end
        end else begin
            for (int i = 0; i < N; i++) begin
                exp_ea[i*DW +: DW] = hist_a[i][i*DW +: DW];
                exp_eb[i*DW +: DW] = hist_b[i][i*DW +: DW];
            end
            check("edge_a", edge_a, exp_ea);
            check("edge_b", edge_b, exp_eb);
            for (int d = N - 1; d > 0; d--) begin
                hist_a[d] = hist_a[d-1];
                hist_b[d] = hist_b[d-1];
            end
            hist_a[0] = exp_acc ? a_vec : '0;
            hist_b[0] = exp_acc ? b_vec : '0;

            if (done) begin
                if (done_q.size() == 0) begin
                    check("done_unexpected", done, 1'b0);
                end else begin
                    check("done_cycle", cyc, done_q.pop_front());
                    for (int i = 0; i < N; i++) begin
                        for (int j = 0; j < N; j++) begin
                            check("pe_sum", acc[i][j], sum_q.pop_front());
                            acc[i][j] = 0;
                        end
                    end
                end
            end

            for (int i = N - 1; i >= 0; i--) begin
                for (int j = N - 1; j >= 0; j--) begin
                    if (j == 0) in_a = edge_a[i*DW +: DW];
                    else        in_a = pa[i][j-1];
                    if (i == 0) in_b = edge_b[j*DW +: DW];
                    else        in_b = pb[i-1][j];
                    acc[i][j] = acc[i][j] + int'(in_a) * int'(in_b);
                    pa[i][j]  = in_a;
                    pb[i][j]  = in_b;
                end
            end
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic clear_exp();
        for (int i = 0; i < N; i++)
            for (int j = 0; j < N; j++)
                exp_sum[i][j] = 0;
    endtask

    task automatic start_job(input int k);
        clear_exp();
        start = 1'b1;
        k_len = KW'(k);
        tick();
        start = 1'b0;
        check("busy_after_start", busy, 1'b1);
    endtask

    task automatic step(input logic [W-1:0] av, input logic [W-1:0] bv);
        a_vec   = av;
        b_vec   = bv;
        a_valid = 1'b1;
        b_valid = 1'b1;
        exp_acc = 1'b1;
        for (int i = 0; i < N; i++)
            for (int j = 0; j < N; j++)
                exp_sum[i][j] += lane(av, i) * lane(bv, j);
        last_l = cyc;
        #1;
        check("a_ready_step", a_ready, 1'b1);
        check("b_ready_step", b_ready, 1'b1);
        tick();
        a_valid = 1'b0;
        b_valid = 1'b0;
        exp_acc = 1'b0;
    endtask

    task automatic push_expect();
        done_q.push_back(last_l + 2 * N);
        for (int i = 0; i < N; i++)
            for (int j = 0; j < N; j++)
                sum_q.push_back(exp_sum[i][j]);
    endtask

    initial begin
        rst = 1'b1; start = 1'b0; k_len = '0;
        a_valid = 1'b0; b_valid = 1'b0; a_vec = '0; b_vec = '0; exp_acc = 1'b0;
        clear_exp();
        repeat (2) tick();
        check("rst_edge_a", edge_a, '0);
        check("rst_edge_b", edge_b, '0);
        check("rst_a_ready", a_ready, 1'b0);
        check("rst_b_ready", b_ready, 1'b0);
        check("rst_busy", busy, 1'b0);
        check("rst_done", done, 1'b0);
`ifdef PE_FEEDER_STALL_CNT_EN
        check("rst_stall_cnt", stall_cnt, 32'd0);
`endif
        rst = 1'b0;
        tick();

        // k_len = 0 start must be ignored
        start = 1'b1; k_len = '0;
        tick();
        start = 1'b0;
        check("zero_k_busy", busy, 1'b0);
        repeat (3) tick();

        // Ones job; k_len changes after start have no effect
        start_job(3);
        k_len = KW'(1);
        repeat (3) step(ramp(1, 0), ramp(1, 0));
        push_expect();
        repeat (2 * N + 3) tick();
        check("ones_idle_busy", busy, 1'b0);

        // Stall bubbles: garbage on the bus while b_valid is low
        start_job(2);
        step(ramp(3, -2), ramp(-4, 3));
        repeat (3) begin
            a_valid = 1'b1; b_valid = 1'b0;
            a_vec = ramp(55, 11); b_vec = ramp(-77, 9);
            #1;
            check("stall_a_ready", a_ready, 1'b0);
            check("stall_b_ready", b_ready, 1'b1);
            check("stall_busy", busy, 1'b1);
            tick();
        end
        step(ramp(-1, 5), ramp(7, -6));
        push_expect();
        repeat (2 * N + 3) tick();
`ifdef PE_FEEDER_STALL_CNT_EN
        check("stall_cnt", stall_cnt, 32'd3);
`endif

        // Signed extremes
        start_job(4);
        repeat (4) step(ramp(-128, 0), ramp(-128, 0));
        push_expect();
        repeat (2 * N + 3) tick();
        start_job(4);
        repeat (4) step(ramp(127, 0), ramp(-128, 0));
        push_expect();
        repeat (2 * N + 3) tick();

        // Mid-job reset during FLUSH: no done, edges cleared at once
        start_job(2);
        step(ramp(9, 1), ramp(8, 1));
        step(ramp(9, 1), ramp(8, 1));
        repeat (2) tick();
        rst = 1'b1;
        #1;
        check("midrst_edge_a", edge_a, '0);
        check("midrst_edge_b", edge_b, '0);
        check("midrst_busy", busy, 1'b0);
        tick();
        rst = 1'b0;
        repeat (2 * N + 4) tick();

        // Fresh job after reset with lane-distinct values
        start_job(3);
        for (int s = 0; s < 3; s++) step(ramp(s * 10 - 20, 3), ramp(-5 * s - 1, -7));
        push_expect();
        repeat (2 * N + 3) tick();

        // Back-to-back: start held high, second job accepted right after DONE
        start = 1'b1; k_len = KW'(1);
        clear_exp();
        tick();
        check("b2b_busy1", busy, 1'b1);
        step(ramp(2, 1), ramp(-3, 2));
        push_expect();
        repeat (2 * N - 1) tick();
        check("b2b_done", done, 1'b1);
        tick();
        check("b2b_idle", busy, 1'b0);
        tick();
        check("b2b_busy2", busy, 1'b1);
        start = 1'b0;
        clear_exp();
        step(ramp(-6, 4), ramp(5, -3));
        push_expect();
        repeat (2 * N + 3) tick();

        check("done_missing", done_q.size(), 0);
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule

// File: doc/pe_skew_feeder.md
# pe_skew_feeder

Input feeder for the Q-projection systolic PE array. Accepts one reduction step at a time (N activation values and N weight values) over a joint valid/ready handshake. Drives the array's left edge (`in_a` of column-0 PEs) and top edge (`in_b` of row-0 PEs) with the diagonal skew the wavefront needs. It zero-fills bubbles and the drain tail, and pulses `done` once every PE accumulator holds its final dot product.

## Interface
- `N`, 4: array dimension (rows = columns = lanes).
- `DATA_WIDTH`, 8: signed element width, matching the PE.
- `K_MAX`, 64: maximum reduction length. `KW = $clog2(K_MAX+1)`.
- `clk`  in  1: single clock.
- `rst`  in  1: reset. Asynchronous, active-high.
- `start`  in  1: begin a job. Sampled only in IDLE.
- `k_len`  in  KW: number of reduction steps. Sampled with `start`.
- `a_valid` / `a_ready`  in/out  1: activation step handshake.
- `a_vec`  in  N*DATA_WIDTH: lane i = A[i][k], signed.
- `b_valid` / `b_ready`  in/out  1: weight step handshake.
- `b_vec`  in  N*DATA_WIDTH: lane j = B[k][j], signed.
- `edge_a`  out  N*DATA_WIDTH: lane i drives the `in_a` of PE(i,0).
- `edge_b`  out  N*DATA_WIDTH: lane j drives the `in_b` of PE(0,j).
- `busy`  out  1: high in FEED and FLUSH.
- `done`  out  1: one-cycle pulse when the array result is complete.

## Operation
- States: IDLE, FEED, FLUSH, DONE.
  - IDLE → FEED on `start` with `k_len != 0`.
  - `start` with `k_len == 0` is ignored; the block stays in IDLE.
- Handshake in FEED:
  - `a_ready = b_valid`; `b_ready = a_valid`.
  - Step accepted when `a_valid && b_valid`. Both streams are consumed in the same cycle, never one without the other.
  - Ready is 0 outside FEED.
- Bubbles: in any cycle with no accepted step (FEED stall, FLUSH, IDLE, DONE), zero is injected into every lane entry.
  - Both streams bubble together, so the diagonal alignment is preserved and each bubble adds product 0 to every PE.
- Skew: each lane is a shift register. Lane i of `edge_a` and lane j of `edge_b` delay the entry value by 1+i and 1+j cycles.
- Step counter counts accepted steps. Reaching `k_len` moves the FSM FEED → FLUSH.
- FLUSH lasts exactly 2N-1 cycles of zero injection, then DONE.
- DONE lasts one cycle with `done=1`, then IDLE.
- `start` outside IDLE is ignored. `k_len` is latched at start; later changes have no effect.
- Reset (including mid-job): all skew registers cleared, so edges are 0. Counters 0, state IDLE.
  - The array is reset by the same `rst`; the feeder never clears PE accumulators.
- No arithmetic: data passes through bit-exact, sign preserved.

## Timing
- Reset values: `edge_a`=0, `edge_b`=0, `a_ready`=0, `b_ready`=0, `busy`=0, `done`=0.
- A step accepted at cycle c reaches `edge_a` lane i at c+1+i, and `edge_b` lane j at c+1+j.
- PE(i,j) sees both operands of that step at cycle c+1+i+j, and its sum includes the step from c+2+i+j.
- Last accept at cycle L gives `done=1` at cycle L+2N. For N=4: L+8.
- `busy` rises the cycle after `start` is accepted, and falls in the DONE cycle.
- Back-to-back jobs: `start` is accepted in the first IDLE cycle after DONE.

## Configuration
- `PE_FEEDER_STALL_CNT_EN`:
  - Defined: adds output `stall_cnt` (32 bits). It counts FEED cycles with no accept, clears on accepted `start`, and saturates at all-ones. It is reset to 0.
  - Undefined: the port and counter are absent. Behaviour is otherwise identical.

## Structure
- Shared package `q_proj_pkg`:
  - `feeder_state_t` enum.
  - `DATA_WIDTH` default.
  - `lane_t` signed element typedef, shared with the PE and the array top.
- Sub-module `skew_delay_line`: parameter DEPTH and width, zero on reset, one instance per lane per edge (2N total).

## Test plan
- Reset check: assert `rst` → all outputs 0, state IDLE. `start` with `k_len=0` → no `busy`, no `done`.
- Ones job: N=4, k_len=3, A=all 1, B=all 1, no stalls. Accepts at cycles 1–3 → `done` at cycle 11, every PE sum = 3. Lane skew verified at `edge_a` lanes 0–3 at cycles 2–5.
- Stall bubbles: k_len=2, `a_valid` high and `b_valid` low for 3 cycles between steps → no accept during the gap, zeros injected. PE(i,j) = Σ A·B, unchanged from the stall-free result. With the macro defined, `stall_cnt`=3.
- Signed extremes: A=-128, B=-128, k_len=4 → every PE = 65536. A=127, B=-128 → every PE = -65024.
- Mid-job reset: assert `rst` during FLUSH → edges 0 immediately, no `done`. A new job afterwards completes correctly.
- Back-to-back jobs: `start` held high with k_len=1 → second job accepted the cycle after the DONE pulse. `start` pulses during FEED are ignored.
